// File: rtl/bubble_page_streamer_if.sv
// Loader-side and pin-side signals of the bubble page streamer.
// master drives the write/control strobes, slave is the streamer itself.
interface bubble_page_streamer_if #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned BITS_PER_LANE = 512
);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned BIT_W  = $clog2(BITS_PER_LANE);

    logic                    nWRCLKEN;
    logic [LANE_W+BIT_W-1:0] WRADDR;
    logic                    WRDATA;
    logic                    nCOMMIT;
    logic                    nSTART;
    logic [LANE_W:0]         ACTLANES;
    logic                    nBOUTCLKEN;
    logic [LANES-1:0]        DOUT;
    logic                    BUSY;
    logic                    nDONE;
    logic                    nUNDERRUN;
    logic                    nOVERRUN;

    modport master (
        output nWRCLKEN, WRADDR, WRDATA, nCOMMIT, nSTART, ACTLANES, nBOUTCLKEN,
        input  DOUT, BUSY, nDONE, nUNDERRUN, nOVERRUN
    );

    modport slave (
        input  nWRCLKEN, WRADDR, WRDATA, nCOMMIT, nSTART, ACTLANES, nBOUTCLKEN,
        output DOUT, BUSY, nDONE, nUNDERRUN, nOVERRUN
    );
endinterface

// File: rtl/bubble_page_streamer.sv
// Ping-pong page buffer filled bit-serially by the loader and streamed out
// one bit per active lane per output strobe.
module bubble_page_streamer #(
    parameter int unsigned LANES         = 4,
    parameter int unsigned BITS_PER_LANE = 512,
    parameter logic        IDLE_LEVEL    = 1'b1
) (
    input  logic                  MCLK,
    input  logic                  nRESET,
    bubble_page_streamer_if.slave bus
);
    localparam int unsigned   LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned   BIT_W    = $clog2(BITS_PER_LANE);
    localparam logic [LANE_W:0] LANES_C  = (LANE_W + 1)'(LANES);
    localparam logic [BIT_W:0]  PAGE_END = (BIT_W + 1)'(BITS_PER_LANE);

    typedef enum logic [1:0] {StIdle, StStream, StEnd} state_e;

    logic [BITS_PER_LANE-1:0] r_mem [2][LANES];

    state_e           r_state;
    logic             r_fill;
    logic             r_ready;
    logic             r_rd_bank;
    logic [LANES-1:0] r_lane_en;
    logic [BIT_W:0]   r_cnt;
    logic [LANES-1:0] r_dout;
    logic             r_busy;
    logic             r_ndone;
    logic             r_nunder;
    logic             r_nover;

    logic [LANE_W-1:0] w_wr_lane;
    logic [BIT_W-1:0]  w_wr_bit;
    logic              w_commit_ok;
    logic [LANE_W:0]   w_act;
    logic [LANES-1:0]  w_lane_mask;
    logic [LANES-1:0]  w_rd_bits;

    assign w_wr_lane   = bus.WRADDR[LANE_W+BIT_W-1:BIT_W];
    assign w_wr_bit    = bus.WRADDR[BIT_W-1:0];
    assign w_commit_ok = !r_ready && !r_busy;

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge MCLK) begin
        if (!bus.nWRCLKEN && ({1'b0, w_wr_lane} < LANES_C)) begin
            r_mem[r_fill][w_wr_lane][w_wr_bit] <= bus.WRDATA;
        end
    end

    // Out-of-range lane counts (including 0) mean all physical lanes.
    always_comb begin
        w_act = bus.ACTLANES;
        if ((bus.ACTLANES == '0) || (bus.ACTLANES > LANES_C)) begin
            w_act = LANES_C;
        end
        w_lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane_mask[i] = ((LANE_W + 1)'(i) < w_act);
        end
    end

    // Next output bits are read ahead from the counter so a strobe loads them directly.
    always_comb begin
        w_rd_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            w_rd_bits[i] = r_lane_en[i] ? r_mem[r_rd_bank][i][r_cnt[BIT_W-1:0]] : IDLE_LEVEL;
        end
    end

    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= StIdle;
            r_fill    <= 1'b0;
            r_ready   <= 1'b0;
            r_rd_bank <= 1'b0;
            r_lane_en <= '0;
            r_cnt     <= '0;
            r_dout    <= {LANES{IDLE_LEVEL}};
            r_busy    <= 1'b0;
            r_ndone   <= 1'b1;
            r_nunder  <= 1'b1;
            r_nover   <= 1'b1;
        end else begin
            r_ndone  <= 1'b1;
            r_nunder <= 1'b1;
            r_nover  <= 1'b1;

            if (!bus.nCOMMIT) begin
                if (w_commit_ok) begin
                    r_fill  <= ~r_fill;
                    r_ready <= 1'b1;
                end else begin
                    r_nover <= 1'b0;
                end
            end

            unique case (r_state)
                StIdle: begin
                    // Start looks at ready before any same-cycle commit lands.
                    if (!bus.nSTART) begin
                        if (r_ready) begin
                            r_rd_bank <= ~r_fill;
                            r_ready   <= 1'b0;
                            r_lane_en <= w_lane_mask;
                            r_cnt     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= StStream;
                        end else begin
                            r_nunder <= 1'b0;
                        end
                    end
                end
                StStream: begin
                    if (!bus.nBOUTCLKEN) begin
                        if (r_cnt == PAGE_END) begin
                            r_dout  <= {LANES{IDLE_LEVEL}};
                            r_busy  <= 1'b0;
                            r_ndone <= 1'b0;
                            r_state <= StEnd;
                        end else begin
                            r_dout <= w_rd_bits;
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                end
                StEnd: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.DOUT      = r_dout;
    assign bus.BUSY      = r_busy;
    assign bus.nDONE     = r_ndone;
    assign bus.nUNDERRUN = r_nunder;
    assign bus.nOVERRUN  = r_nover;
endmodule

// File: tb/tb_bubble_page_streamer.sv
// Self-checking bench for bubble_page_streamer: lane-count table plus
// ping-pong, overrun/underrun and mid-stream reset sequences.
module tb_bubble_page_streamer;
    localparam int unsigned LANES = 4;
    localparam int unsigned BPL   = 8;

    // Pages packed lane3..lane0, 8 bits per lane, LSB = bit 0.
    localparam logic [31:0] PAGE_A = {8'h00, 8'hFF, 8'h3C, 8'hA5};
    localparam logic [31:0] PAGE_B = {8'h78, 8'h56, 8'h34, 8'h12};

    logic MCLK   = 1'b0;
    logic nRESET = 1'b0;

    bubble_page_streamer_if #(.LANES(LANES), .BITS_PER_LANE(BPL)) bus ();

    bubble_page_streamer #(
        .LANES        (LANES),
        .BITS_PER_LANE(BPL),
        .IDLE_LEVEL   (1'b1)
    ) dut (
        .MCLK  (MCLK),
        .nRESET(nRESET),
        .bus   (bus)
    );

    always #5 MCLK = ~MCLK;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [2:0] act;
        logic [3:0] e0;
        logic [3:0] e1;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge MCLK);
        #1;
    endtask

    function automatic logic [3:0] model(input logic [31:0] pg, input int act, input int k);
        logic [3:0] m;
        int eff;
        eff = ((act == 0) || (act > LANES)) ? LANES : act;
        m = 4'b1111;
        if (k < BPL) begin
            for (int i = 0; i < eff; i++) m[i] = pg[i*8+k];
        end
        return m;
    endfunction

    task automatic write_page(input logic [31:0] pg);
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < BPL; b++) begin
                bus.nWRCLKEN = 1'b0;
                bus.WRADDR   = {2'(l), 3'(b)};
                bus.WRDATA   = pg[l*8+b];
                cyc();
            end
        end
        bus.nWRCLKEN = 1'b1;
    endtask

    task automatic commit();
        bus.nCOMMIT = 1'b0;
        cyc();
        bus.nCOMMIT = 1'b1;
    endtask

    task automatic start(input logic [2:0] act);
        bus.ACTLANES = act;
        bus.nSTART   = 1'b0;
        cyc();
        bus.nSTART   = 1'b1;
        check("start_busy", 32'(bus.BUSY), 32'd1);
        check("start_no_underrun", 32'(bus.nUNDERRUN), 32'd1);
    endtask

    task automatic strobe(input string name, input bit hold);
        logic [3:0] e;
        bus.nBOUTCLKEN = 1'b0;
        cyc();
        bus.nBOUTCLKEN = 1'b1;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(bus.DOUT), 32'(e));
            if (hold) begin
                cyc();
                check({name, "_hold"}, 32'(bus.DOUT), 32'(e));
                cyc();
            end
        end
    endtask

    task automatic stream_page(input string name, input logic [31:0] pg, input int act,
                               input logic [3:0] e0, input logic [3:0] e1);
        for (int k = 0; k <= BPL; k++) begin
            exp_q.push_back((k == 0) ? e0 : (k == 1) ? e1 : model(pg, act, k));
            strobe($sformatf("%s_dout_s%0d", name, k), k < BPL);
        end
        check({name, "_done_low"}, 32'(bus.nDONE), 32'd0);
        check({name, "_busy_off"}, 32'(bus.BUSY), 32'd0);
        cyc();
        check({name, "_done_1cyc"}, 32'(bus.nDONE), 32'd1);
        check({name, "_busy_stays_off"}, 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd4, 4'b0101, 4'b0100};
        vecs[1] = '{3'd1, 4'b1111, 4'b1110};
        vecs[2] = '{3'd0, 4'b0101, 4'b0100};
        vecs[3] = '{3'd2, 4'b1101, 4'b1100};
        vecs[4] = '{3'd7, 4'b0101, 4'b0100};

        bus.nWRCLKEN   = 1'b1;
        bus.WRADDR     = '0;
        bus.WRDATA     = 1'b0;
        bus.nCOMMIT    = 1'b1;
        bus.nSTART     = 1'b1;
        bus.ACTLANES   = 3'd4;
        bus.nBOUTCLKEN = 1'b1;

        // Reset state
        repeat (3) cyc();
        check("rst_dout", 32'(bus.DOUT), 32'hF);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        nRESET = 1'b1;
        cyc();
        check("rel_dout", 32'(bus.DOUT), 32'hF);
        check("rel_busy", 32'(bus.BUSY), 32'd0);
        check("rel_ndone", 32'(bus.nDONE), 32'd1);
        check("rel_nunder", 32'(bus.nUNDERRUN), 32'd1);
        check("rel_nover", 32'(bus.nOVERRUN), 32'd1);
        bus.nSTART = 1'b0;
        cyc();
        bus.nSTART = 1'b1;
        check("empty_start_underrun", 32'(bus.nUNDERRUN), 32'd0);
        check("empty_start_busy", 32'(bus.BUSY), 32'd0);
        cyc();
        check("underrun_1cyc", 32'(bus.nUNDERRUN), 32'd1);

        // Lane-count table on page A
        for (int v = 0; v < 5; v++) begin
            write_page(PAGE_A);
            commit();
            check($sformatf("tbl%0d_commit_ok", v), 32'(bus.nOVERRUN), 32'd1);
            start(vecs[v].act);
            stream_page($sformatf("tbl%0d", v), PAGE_A, int'(vecs[v].act), vecs[v].e0,
                        vecs[v].e1);
        end

        // Ping-pong: fill B while A streams
        write_page(PAGE_A);
        commit();
        start(3'd4);
        write_page(PAGE_B);
        check("pp_dout_idle_before_strobe", 32'(bus.DOUT), 32'hF);
        commit();
        check("pp_commit_busy_overrun", 32'(bus.nOVERRUN), 32'd0);
        cyc();
        check("pp_overrun_1cyc", 32'(bus.nOVERRUN), 32'd1);
        stream_page("pp_a", PAGE_A, 4, 4'b0101, 4'b0100);
        commit();
        check("pp_commit_after_done", 32'(bus.nOVERRUN), 32'd1);
        start(3'd4);
        stream_page("pp_b", PAGE_B, 4, 4'b0000, 4'b0101);

        // Double commit without start
        write_page(PAGE_A);
        commit();
        check("dc_first_ok", 32'(bus.nOVERRUN), 32'd1);
        commit();
        check("dc_second_overrun", 32'(bus.nOVERRUN), 32'd0);
        cyc();
        check("dc_overrun_1cyc", 32'(bus.nOVERRUN), 32'd1);
        start(3'd4);
        stream_page("dc", PAGE_A, 4, 4'b0101, 4'b0100);

        // Simultaneous start and commit from empty
        write_page(PAGE_B);
        bus.nSTART  = 1'b0;
        bus.nCOMMIT = 1'b0;
        cyc();
        bus.nSTART  = 1'b1;
        bus.nCOMMIT = 1'b1;
        check("sim_underrun", 32'(bus.nUNDERRUN), 32'd0);
        check("sim_no_overrun", 32'(bus.nOVERRUN), 32'd1);
        check("sim_not_busy", 32'(bus.BUSY), 32'd0);
        cyc();
        start(3'd4);
        stream_page("sim", PAGE_B, 4, 4'b0000, 4'b0101);

        // Reset after strobe 3 of 8
        write_page(PAGE_A);
        commit();
        start(3'd4);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(model(PAGE_A, 4, k));
            strobe($sformatf("mrst_dout_s%0d", k), 1'b1);
        end
        #2;
        nRESET = 1'b0;
        #1;
        check("mrst_dout_idle", 32'(bus.DOUT), 32'hF);
        check("mrst_busy_off", 32'(bus.BUSY), 32'd0);
        for (int c = 0; c < 2; c++) begin
            cyc();
            check("mrst_no_done", 32'(bus.nDONE), 32'd1);
        end
        nRESET = 1'b1;
        cyc();
        check("mrst_no_done_after", 32'(bus.nDONE), 32'd1);
        bus.nSTART = 1'b0;
        cyc();
        bus.nSTART = 1'b1;
        check("mrst_start_underrun", 32'(bus.nUNDERRUN), 32'd0);
        check("mrst_start_not_busy", 32'(bus.BUSY), 32'd0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
